// File: rtl/poly_arith_pkg.sv
// Shared arithmetic constants and types for the polynomial datapath.
// Holds the modulus, operand widths, reducer latency and requester tag types.
package poly_arith_pkg;

  localparam int KYBER_Q        = 3329;
  localparam int PROD_W         = 24;
  localparam int COEF_W         = 12;
  localparam int REDUCE_LATENCY = 2;
  localparam int NUM_REQ        = 2;

  typedef logic req_id_t;

  // One slot of the in-flight tag pipe: which requester owns the reducer result.
  typedef struct packed {
    logic    valid;
    req_id_t owner;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant, pointer registered on a
// completed grant. The pointer remembers the last winner and resets to 1.
module rr_arbiter
  import poly_arith_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  req_id_t last_q;

  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    if (valid == 2'b11) begin
      grant_id = ~last_q;
    end else begin
      grant_id = valid[1];
    end
    if (valid != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (grant != 2'b00) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/reduce_arbiter.sv
// Shares one pipelined modular reducer between two requesters and routes each
// result back to its owner. Define REDUCE_ARB_CHECK_EN to enable the tag checker.
module reduce_arbiter
  import poly_arith_pkg::*;
#(
  parameter int LATENCY = REDUCE_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid_i,
  input  logic [1:0][PROD_W-1:0]    req_product_i,
  output logic [1:0]                req_ready_o,
  output logic                      red_valid_o,
  output logic [PROD_W-1:0]         red_product_o,
  input  logic                      red_valid_i,
  input  logic [COEF_W-1:0]         red_result_i,
  output logic [1:0]                rsp_valid_o,
  output logic [COEF_W-1:0]         rsp_result_o,
  output logic                      busy_o,
  output logic                      err_o
);

  // Handshake: a request transfers in the cycle where req_valid_i[n] and
  // req_ready_o[n] are both high; ready never depends on the reducer.
  logic [1:0] grant;
  req_id_t    grant_id;
  req_id_t    red_owner_q;
  logic       handshake;
  tag_t       tag_q [LATENCY];
  tag_t       head;

  rr_arbiter u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .valid    (req_valid_i),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready_o = rst ? grant : 2'b00;
  assign handshake   = (req_ready_o != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red_valid_o   <= 1'b0;
      red_product_o <= '0;
      red_owner_q   <= 1'b0;
    end else begin
      red_valid_o <= handshake;
      if (handshake) begin
        red_product_o <= req_product_i[grant_id];
        red_owner_q   <= grant_id;
      end
    end
  end

  // Tag pipe mirrors the reducer latency so the head lines up with red_valid_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_t'{valid: red_valid_o, owner: red_owner_q};
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign head         = tag_q[LATENCY-1];
  assign rsp_result_o = red_result_i;

  always_comb begin
    rsp_valid_o = 2'b00;
    if (red_valid_i && head.valid) begin
      rsp_valid_o[head.owner] = 1'b1;
    end
  end

  always_comb begin
    busy_o = red_valid_o;
    for (int i = 0; i < LATENCY; i++) begin
      busy_o = busy_o | tag_q[i].valid;
    end
  end

`ifdef REDUCE_ARB_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (red_valid_i != head.valid) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_reduce_arbiter.sv
// Directed bench for reduce_arbiter with a behavioural reducer of fixed latency.
// Covers single ops, alternation, hold-then-join, mid-flight reset and the checker.
module tb_reduce_arbiter;
  import poly_arith_pkg::*;

  localparam int LAT = REDUCE_LATENCY;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [1:0]             req_valid = 2'b00;
  logic [1:0][PROD_W-1:0] req_product = '0;
  logic [1:0]             req_ready;
  logic                   red_valid_o;
  logic [PROD_W-1:0]      red_product_o;
  logic                   red_valid_i;
  logic [COEF_W-1:0]      red_result_i;
  logic [1:0]             rsp_valid;
  logic [COEF_W-1:0]      rsp_result;
  logic                   busy;
  logic                   err;
  logic                   inject = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  logic [LAT-1:0]    mv = '0;
  logic [COEF_W-1:0] mr [LAT];

  always #5 clk = ~clk;

  reduce_arbiter #(.LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_product_i (req_product),
    .req_ready_o   (req_ready),
    .red_valid_o   (red_valid_o),
    .red_product_o (red_product_o),
    .red_valid_i   (red_valid_i),
    .red_result_i  (red_result_i),
    .rsp_valid_o   (rsp_valid),
    .rsp_result_o  (rsp_result),
    .busy_o        (busy),
    .err_o         (err)
  );

  // Reducer stand-in: not reset, so in-flight results survive a DUT reset.
  always @(posedge clk) begin
    mv[0] <= red_valid_o;
    mr[0] <= COEF_W'(int'(red_product_o) % KYBER_Q);
    for (int i = 1; i < LAT; i++) begin
      mv[i] <= mv[i-1];
      mr[i] <= mr[i-1];
    end
  end

  assign red_valid_i  = mv[LAT-1] | inject;
  assign red_result_i = mr[LAT-1];

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    req_product[0] = 24'h000123;
    req_product[1] = 24'h000456;
    @(negedge clk); #1;
    compared++; if (req_ready !== 2'b00) begin mismatched++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (red_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_red_valid: got %b want 0", red_valid_o); end
    compared++; if (red_product_o !== 24'h0) begin mismatched++; $display("FAIL reset_red_product: got %h want 000000", red_product_o); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_op(input int id, input logic [PROD_W-1:0] product,
                                input logic [COEF_W-1:0] exp_result);
    logic [1:0] exp_oh;
    exp_oh = 2'b01 << id;
    @(negedge clk);
    req_valid = exp_oh;
    req_product[id] = product;
    #1;
    compared++; if (req_ready !== exp_oh) begin mismatched++; $display("FAIL single%0d_ready: got %b want %b", id, req_ready, exp_oh); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    compared++; if (red_valid_o !== 1'b1) begin mismatched++; $display("FAIL single%0d_red_valid: got %b want 1", id, red_valid_o); end
    compared++; if (red_product_o !== product) begin mismatched++; $display("FAIL single%0d_red_product: got %h want %h", id, red_product_o, product); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single%0d_busy: got %b want 1", id, busy); end
    @(negedge clk); #1;
    compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL single%0d_early_rsp: got %b want 00", id, rsp_valid); end
    @(negedge clk); #1;
    compared++; if (rsp_valid !== exp_oh) begin mismatched++; $display("FAIL single%0d_rsp_valid: got %b want %b", id, rsp_valid, exp_oh); end
    compared++; if (rsp_result !== exp_result) begin mismatched++; $display("FAIL single%0d_rsp_result: got %0d want %0d", id, rsp_result, exp_result); end
    @(negedge clk); #1;
    compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL single%0d_rsp_after: got %b want 00", id, rsp_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single%0d_idle_busy: got %b want 0", id, busy); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL single%0d_err: got %b want 0", id, err); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]        exp_ready, exp_rsp;
    logic [COEF_W-1:0] exp_res;
    logic              exp_busy;
    int                k;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 6) begin
        req_valid = 2'b11;
        req_product[0] = PROD_W'(KYBER_Q * c + 5 + c);
        req_product[1] = PROD_W'(KYBER_Q * (c + 1) + 200 + c);
      end else begin
        req_valid = 2'b00;
      end
      #1;
      exp_ready = (c < 6) ? ((c % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      compared++; if (req_ready !== exp_ready) begin mismatched++; $display("FAIL b2b_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      exp_rsp = 2'b00;
      exp_res = '0;
      if (c >= 3 && c <= 8) begin
        k = c - 3;
        exp_rsp = (k % 2 == 1) ? 2'b10 : 2'b01;
        exp_res = (k % 2 == 1) ? COEF_W'(200 + k) : COEF_W'(5 + k);
      end
      compared++; if (rsp_valid !== exp_rsp) begin mismatched++; $display("FAIL b2b_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 2'b00) begin
        compared++; if (rsp_result !== exp_res) begin mismatched++; $display("FAIL b2b_rsp_result c%0d: got %0d want %0d", c, rsp_result, exp_res); end
      end
      exp_busy = (c >= 1 && c <= 8);
      compared++; if (busy !== exp_busy) begin mismatched++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy, exp_busy); end
    end
  endtask

  task automatic test_hold_then_join();
    logic [1:0] exp_ready [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [1:0] exp_rsp;
    req_product[0] = 24'd9;
    req_product[1] = 24'd7;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = (c < 3) ? 2'b10 : ((c == 3) ? 2'b11 : 2'b00);
      #1;
      if (c < 5) begin
        compared++; if (req_ready !== exp_ready[c]) begin mismatched++; $display("FAIL hold_ready c%0d: got %b want %b", c, req_ready, exp_ready[c]); end
      end
      exp_rsp = (c >= 3 && c <= 5) ? 2'b10 : ((c == 6) ? 2'b01 : 2'b00);
      compared++; if (rsp_valid !== exp_rsp) begin mismatched++; $display("FAIL hold_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 2'b00) begin
        compared++; if (rsp_result !== ((c == 6) ? 12'd9 : 12'd7)) begin mismatched++; $display("FAIL hold_rsp_result c%0d: got %0d", c, rsp_result); end
      end
    end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL hold_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    req_valid = 2'b01;
    req_product[0] = 24'd3335;
    #1;
    compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL midrst_ready0: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10;
    req_product[1] = 24'd3340;
    #1;
    compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL midrst_ready1: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
    compared++; if (red_valid_o !== 1'b0) begin mismatched++; $display("FAIL midrst_red_valid: got %b want 0", red_valid_o); end
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL midrst_rsp c%0d: got %b want 00", c, rsp_valid); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy_after c%0d: got %b want 0", c, busy); end
    end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL midrst_first_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_check();
    logic exp_err;
`ifdef REDUCE_ARB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL check_err_clear: got %b want 0", err); end
    @(negedge clk);
    inject = 1'b1;
    #1;
    compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL check_spurious_rsp: got %b want 00", rsp_valid); end
    @(negedge clk);
    inject = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      compared++; if (err !== exp_err) begin mismatched++; $display("FAIL check_err_sticky c%0d: got %b want %b", c, err, exp_err); end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL check_err_reset: got %b want 0", err); end
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_op(0, 24'h000D02, 12'd1);
    test_single_op(1, 24'hA90000, 12'd1);
    test_back_to_back();
    test_hold_then_join();
    test_reset_midflight();
    test_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reduce_arbiter.md
REDUCE_ARBITER -- requirements
Module: reduce_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default REDUCE_LATENCY (package, value 2), meaning modular-reducer cycles from input valid to output valid.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid_i  input  2  per-requester request valid (bit 0 = requester 0).
REQ-005 SHALL have port req_product_i  input  2x24  per-requester 24-bit product to reduce mod q.
REQ-006 SHALL have port req_ready_o  output  2  per-requester grant; a handshake is valid & ready in the same cycle.
REQ-007 SHALL have port red_valid_o  output  1  valid to the shared modular reducer.
REQ-008 SHALL have port red_product_o  output  24  product to the shared modular reducer.
REQ-009 SHALL have port red_valid_i  input  1  valid from the shared modular reducer.
REQ-010 SHALL have port red_result_i  input  12  reduced result from the shared modular reducer.
REQ-011 SHALL have port rsp_valid_o  output  2  one-hot response valid to the owning requester.
REQ-012 SHALL have port rsp_result_o  output  12  response data, shared by both requesters.
REQ-013 SHALL have port busy_o  output  1  high while any operation is issued or in flight.
REQ-014 SHALL have port err_o  output  1  sticky tracking-mismatch flag (see Configuration).

Function
REQ-015 SHALL drive req_ready_o combinationally: at most one bit set, and only for a requester with valid set.
REQ-016 SHALL grant the sole requester when only one is valid.
REQ-017 SHALL grant the requester not granted last when both are valid (round-robin); the pointer resets to "last = 1" so requester 0 wins first.
REQ-018 SHALL update the round-robin pointer only on a completed handshake.
REQ-019 SHALL register a granted product into red_product_o, with red_valid_o = 1 in cycle T+1 for a handshake in cycle T; red_valid_o = 0 in cycles with no handshake.
REQ-020 SHALL accept one handshake per cycle with no bubbles (full throughput, no back-pressure from the reducer).
REQ-021 SHALL push the owner ID and a valid bit into a LATENCY-deep tag shift register when red_valid_o is issued, so the head aligns with red_valid_i at cycle T+1+LATENCY.
REQ-022 SHALL, when red_valid_i = 1, assert rsp_valid_o[head owner] combinationally in the same cycle with rsp_result_o = red_result_i.
REQ-023 SHALL hold rsp_valid_o = 0 when red_valid_i = 0; rsp_result_o is then don't-care.
REQ-024 SHALL treat responses as non-stallable; requesters accept rsp_valid_o unconditionally.
REQ-025 SHALL drive busy_o = red_valid_o OR any tag valid bit.

Reset
REQ-026 SHALL, on rst low, asynchronously clear red_valid_o, all tag valid bits, the round-robin pointer (last = 1), and err_o; red_product_o is cleared to 0.
REQ-027 SHALL give req_ready_o = 0, rsp_valid_o = 0 and busy_o = 0 while reset is asserted.
REQ-028 SHALL discard in-flight operations on reset mid-operation: reducer outputs arriving after reset release produce no rsp_valid_o, because their tags are cleared.

Configuration
REQ-029 SHALL, with REDUCE_ARB_CHECK_EN defined, set err_o sticky-high when red_valid_i differs from the tag-head valid bit; only reset clears it.
REQ-030 SHALL, without REDUCE_ARB_CHECK_EN, tie err_o to 0 and synthesize no checker logic.

Structure
REQ-031 SHALL take KYBER_Q (3329), REDUCE_LATENCY, the product and coefficient width constants, and the req_id_t typedef from poly_arith_pkg.
REQ-032 SHALL implement arbitration in one sub-module, rr_arbiter (2-way round-robin, combinational grant, registered pointer).

Verification
REQ-033 SHALL cover: requester 0 sends product 24'h000D02 (3330) at cycle T -> rsp_valid_o = 2'b01 and rsp_result_o = 1 at T+1+LATENCY.
REQ-034 SHALL cover: both valid continuously for 6 cycles -> grants 0,1,0,1,0,1; responses return in the same order to the matching requester; busy_o stays high until the last response.
REQ-035 SHALL cover: requester 1 sends 24'hA90000 (3328*3328) -> rsp_valid_o = 2'b10 and rsp_result_o = 1.
REQ-036 SHALL cover: rst pulled low with 2 operations in flight -> no rsp_valid_o afterwards, busy_o = 0, first grant after release goes to requester 0.
REQ-037 SHALL cover: with REDUCE_ARB_CHECK_EN, a spurious red_valid_i injected with an empty tag pipe -> err_o = 1 and held until reset.
REQ-038 SHALL cover: requester 1 holds valid alone for 3 cycles, then requester 0 joins -> grants 1,1,1, then 0.
